// File: rtl/lsu.sv
// Load/store unit: bridges the core data port to a valid/ready word memory,
// forming byte lanes for stores and extending load results.
module lsu #(
  parameter int unsigned AW      = 30,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    funct3,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          misaligned,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt;
  logic          req_mis;
  logic          mis_n;
  logic          abort_n;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic [31:0]   shifted;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
  always_comb begin
    unique case (funct3[1:0])
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = addr[0];
      default: req_mis = (addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    unique case (f3_q[1:0])
      2'b00: begin
        be_c = 4'b0001 << addr_q[1:0];
        wd_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << addr_q[1:0];
        wd_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    mis_n   = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        mis_n   = req_mis;
        state_n = req_mis ? RESP : REQ;
      end
      REQ: begin
        if (mem_ready) state_n = we_q ? RESP : WAIT;
        else if (cnt == CNT_MAX) begin
          state_n = RESP;
          abort_n = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) state_n = RESP;
        else if (cnt == CNT_MAX) begin
          state_n = RESP;
          abort_n = 1'b1;
        end
      end
      RESP: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      misaligned <= mis_n;
      bus_err    <= abort_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      // Counter restarts on every entry into REQ or WAIT
      if (state_n != state && (state_n == REQ || state_n == WAIT)) cnt <= '0;
      else if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && mem_rvalid) rdata <= load_ext;
    end
  end

  assign stall     = (state == IDLE && req_valid) || state == REQ || state == WAIT;
  assign done      = (state == RESP);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_c : '0;
  assign mem_wdata = mem_req ? wd_c : '0;
  assign mem_addr  = addr_q[AW+1:2];

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the single-cycle core's data-memory port and a word-wide memory with a valid/ready handshake. It takes one load or store per request and stalls the core until the access completes. It forms byte enables and shifted write data for SB/SH/SW, and sign- or zero-extends LB/LH/LW/LBU/LHU results. It flags misaligned accesses without touching memory, and aborts accesses the memory fails to answer within a bounded number of cycles.

## Interface
Parameters:
- AW, 30: word-address width on the memory side; byte address bits [AW+1:2] are used.
- TIMEOUT, 16: maximum cycles spent waiting in REQ or in WAIT before abort; must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core has a memory instruction this cycle
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  core must hold PC/regfile write
- done  out  1  one-cycle pulse: access complete, rdata/err valid
- rdata  out  32  extended load result, held until next done
- misaligned  out  1  valid with done: address misaligned for width
- bus_err  out  1  valid with done: timeout abort
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write
- mem_addr  out  AW  word address
- mem_be  out  4  byte enables (bit i = byte lane i, little-endian)
- mem_wdata  out  32  lane-aligned write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: when req_valid=1, capture req_we, funct3, addr, and wdata into registers. If the access is aligned, go to REQ. If it is misaligned (H/HU with addr[0]=1, W with addr[1:0]≠0), go to RESP with misaligned=1.
- funct3 values 011, 110 and 111 are treated as W.
- REQ: mem_req=1 and all mem_* outputs come from the captured registers. On mem_req & mem_ready:
  - store → RESP.
  - load → WAIT.
- WAIT: on mem_rvalid, register the extended result into rdata and go to RESP.
- RESP: done=1 for exactly one cycle, then IDLE. req_valid is ignored in RESP; it still belongs to the completing instruction.
- Timeout: a counter clears on entry to REQ and again on entry to WAIT, and increments every cycle in those states. When the counter reaches TIMEOUT-1 without the exit condition, go to RESP with bus_err=1.
  - rdata is unchanged on a bus_err.
  - mem_req drops on the abort.
- stall = (state==IDLE & req_valid) | state==REQ | state==WAIT. stall is combinational from req_valid in IDLE and is low in RESP.
- Byte enables and write data use o = addr[1:0]:
  - B: be = 0001<<o; wdata byte replicated to all four lanes.
  - H: be = 0011<<o; halfword replicated to both halves.
  - W: be = 1111; wdata unchanged.
  - For loads, mem_be uses the same pattern.
- Load extract: select the lane at byte offset o (B) or o[1] (H). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- misaligned and bus_err are registered. They are meaningful only while done=1, and cleared otherwise.
- Reset: state=IDLE, counter=0, rdata=0; done, misaligned, bus_err, mem_req, mem_we, mem_be and mem_wdata are 0; mem_addr=0.
- Reset asserted in REQ or WAIT aborts the access: no done pulse, and mem_req is 0 the next cycle. Any rvalid after reset is ignored.

## Timing
- Request presented at cycle N in IDLE → mem_req high from N+1.
- Store with mem_ready at N+1: done at N+2; the core advances at the end of N+2. Total is 3 cycles, stall high at N and N+1.
- Load with mem_ready at N+1 and mem_rvalid at N+2: done and rdata at N+3.
- mem_rvalid asserted in the same cycle as mem_ready is not sampled. Memory must return data no earlier than the cycle after acceptance.
- Misaligned request at N: done and misaligned at N+1; no mem_req.
- mem_* outputs are stable while mem_req=1 and not yet accepted.
- Back-to-back: a new req_valid in the cycle after RESP starts the next access immediately.

## Test plan
- SW addr=0x0000_0104, wdata=0xDEADBEEF, mem_ready at first cycle → mem_addr=0x41, be=1111, mem_wdata=0xDEADBEEF; done 2 cycles after request; stall high for exactly 2 cycles.
- SB addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5. SH addr=0x102 → be=1100.
- mem_rdata=0x80FF7F01 at word 0x40, with mem_rvalid delayed 3 cycles:
  - LB @0x100 → 0x00000001
  - LB @0x103 → 0xFFFFFF80
  - LBU @0x102 → 0x000000FF
  - LH @0x102 → 0xFFFF80FF
  - LHU @0x100 → 0x00007F01
  - LW → 0x80FF7F01
- LW addr=0x102 and LH addr=0x101 → done+misaligned the next cycle, mem_req never asserts, rdata unchanged.
- mem_ready held low with TIMEOUT=16 → mem_req high for 16 cycles, then done+bus_err. A later load accepted but with no rvalid for 16 cycles → bus_err, rdata unchanged.
- reset pulse while in WAIT → outputs at reset values next cycle, no done. A late mem_rvalid is ignored, and the next load completes normally.
